// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared constants and types for the HD44780-style bus receiver:
//   - opcode masks/values used by the instruction decoder
//   - DDRAM geometry (2 lines x 16 characters = 32 bytes)
//   - FSM state enum and the decoded-instruction enum
//   - lcd_decode(): highest-set-bit-first instruction classifier
// ---------------------------------------------------------------------------
package lcd_pkg;

  localparam int DDRAM_DEPTH = 32;
  localparam int DDRAM_AW    = 5;

  localparam logic [7:0] LCD_SPACE     = 8'h20;
  localparam logic [7:0] OP_CLEAR      = 8'h01;
  localparam logic [7:0] OP_HOME_MASK  = 8'hFE;
  localparam logic [7:0] OP_HOME       = 8'h02;
  localparam logic [7:0] OP_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] OP_ENTRY      = 8'h04;
  localparam int         OP_DDRAM_BIT  = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } lcd_state_e;

  typedef enum logic [2:0] {
    CMD_OTHER,
    CMD_SET_ADDR,
    CMD_ENTRY,
    CMD_HOME,
    CMD_CLEAR
  } lcd_cmd_e;

  // Masks encode "all higher bits zero", so checking in this order gives
  // highest-set-bit-first priority.
  function automatic lcd_cmd_e lcd_decode(input logic [7:0] op);
    lcd_cmd_e cmd;
    cmd = CMD_OTHER;
    if (op[OP_DDRAM_BIT])                          cmd = CMD_SET_ADDR;
    else if ((op & OP_ENTRY_MASK) == OP_ENTRY)     cmd = CMD_ENTRY;
    else if ((op & OP_HOME_MASK) == OP_HOME)       cmd = CMD_HOME;
    else if (op == OP_CLEAR)                       cmd = CMD_CLEAR;
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_bus_receiver_if.sv
// ---------------------------------------------------------------------------
// lcd_bus_receiver_if
// HD44780-style parallel write bus.
//   RS       : 0 = instruction, 1 = data
//   RW       : 1 = read request (the receiver discards these)
//   enable_l : active-low enable; the transfer latches on its rising edge
//   bus      : instruction/data byte
// Handshake: there is no ready/back-pressure. The master holds RS/RW/bus
// stable while enable_l is low and across its rising edge; each 0->1 edge
// of enable_l is exactly one transfer. Flow control is by timing only
// (busy is advisory).
// Modports: master drives the bus, slave (the receiver) observes it.
// ---------------------------------------------------------------------------
interface lcd_bus_receiver_if;
  logic       RS;
  logic       RW;
  logic       enable_l;
  logic [7:0] bus;

  modport master (output RS, output RW, output enable_l, output bus);
  modport slave  (input  RS, input  RW, input  enable_l, input  bus);
endinterface

// File: rtl/lcd_sync.sv
// ---------------------------------------------------------------------------
// lcd_sync
// STAGES-deep flop synchronizer for a WIDTH-bit bundle. Reset loads
// RESET_VAL into every stage so the bus looks idle while in reset.
// Ports: clock, reset (sync, active-high), d_i (async bundle),
//        q_o (synchronized bundle, last stage).
// ---------------------------------------------------------------------------
module lcd_sync #(
  parameter int                 STAGES    = 2,
  parameter int                 WIDTH     = 11,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/lcd_bus_receiver.sv
// ---------------------------------------------------------------------------
// lcd_bus_receiver
// Responder for the HD44780-style write bus. Synchronizes the bus, latches
// one transfer per rising edge of enable_l, and mirrors it into a 2x16 DDRAM
// model with cursor and entry-mode (I/D) state. Clear Display runs a 32-cycle
// walk writing spaces to every index.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   lcd (slave)       : RS / RW / enable_l / bus
//   rd_addr, rd_data  : DDRAM read port, 1-cycle registered latency
//   cursor            : current DDRAM index
//   busy              : walk in progress (or busy window when enabled)
//   data_strobe       : 1-cycle pulse per accepted data write
//   cmd_strobe        : 1-cycle pulse per accepted instruction
//   violation         : sticky, transfer arrived while busy
//   state_dbg         : FSM state
// Build option: LCD_RX_BUSY_CHECK_EN compiles in the busy-window counters
// and the violation flag; without it violation is tied low.
// ---------------------------------------------------------------------------
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int CMD_BUSY_CYCLES   = 40,
  parameter int CLEAR_BUSY_CYCLES = 1600
) (
  input  logic                  clock,
  input  logic                  reset,
  lcd_bus_receiver_if.slave     lcd,
  input  logic [DDRAM_AW-1:0]   rd_addr,
  output logic [7:0]            rd_data,
  output logic [DDRAM_AW-1:0]   cursor,
  output logic                  busy,
  output logic                  data_strobe,
  output logic                  cmd_strobe,
  output logic                  violation,
  output lcd_state_e            state_dbg
);

  if (SYNC_STAGES < 2 || CMD_BUSY_CYCLES < 1 || CLEAR_BUSY_CYCLES < 32) begin : g_param_check
    $error("lcd_bus_receiver: illegal parameter set");
  end

  // ---- input synchronizer: {enable_l, RS, RW, bus}, idle = enable_l high
  logic [10:0] sync_s;
  lcd_sync #(.STAGES(SYNC_STAGES), .WIDTH(11), .RESET_VAL(11'h400)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   ({lcd.enable_l, lcd.RS, lcd.RW, lcd.bus}),
    .q_o   (sync_s)
  );

  // ---- edge capture: one register stage so the commit lands at k+SYNC_STAGES+1
  logic       en_prev_q, xfer_vld_q, rs_q, rw_q;
  logic [7:0] bus_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      en_prev_q  <= 1'b1;
      xfer_vld_q <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      bus_q      <= 8'h00;
    end else begin
      en_prev_q  <= sync_s[10];
      xfer_vld_q <= sync_s[10] & ~en_prev_q;
      rs_q       <= sync_s[9];
      rw_q       <= sync_s[8];
      bus_q      <= sync_s[7:0];
    end
  end

  // Read requests are discarded before they reach the FSM.
  logic xfer_go;
  assign xfer_go = xfer_vld_q & ~rw_q;

  // ---- FSM and architectural state
  lcd_state_e          state_q;
  logic [DDRAM_AW-1:0] walk_q, cursor_q;
  logic                id_q, data_stb_q, cmd_stb_q;
`ifdef LCD_RX_BUSY_CHECK_EN
  localparam int CNT_W = $clog2(CLEAR_BUSY_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             viol_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      walk_q     <= '0;
      cursor_q   <= '0;
      id_q       <= 1'b1;
      data_stb_q <= 1'b0;
      cmd_stb_q  <= 1'b0;
`ifdef LCD_RX_BUSY_CHECK_EN
      cnt_q      <= '0;
      viol_q     <= 1'b0;
`endif
    end else begin
      data_stb_q <= 1'b0;
      cmd_stb_q  <= 1'b0;
`ifdef LCD_RX_BUSY_CHECK_EN
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
`endif
      case (state_q)
        ST_CLEAR: begin
          // Walk writes index walk_q this edge; leave after index 31.
          walk_q <= walk_q + 1'b1;
          if (walk_q == DDRAM_AW'(DDRAM_DEPTH - 1)) state_q <= ST_IDLE;
`ifdef LCD_RX_BUSY_CHECK_EN
          if (xfer_go) viol_q <= 1'b1;
`endif
        end
        default: begin
          if (xfer_go) begin
`ifdef LCD_RX_BUSY_CHECK_EN
            if (cnt_q != '0) viol_q <= 1'b1;
            cnt_q <= CNT_W'(CMD_BUSY_CYCLES);
`endif
            if (rs_q) begin
              data_stb_q <= 1'b1;
              cursor_q   <= id_q ? cursor_q + 1'b1 : cursor_q - 1'b1;
            end else begin
              cmd_stb_q <= 1'b1;
              case (lcd_decode(bus_q))
                CMD_SET_ADDR: cursor_q <= {bus_q[6], bus_q[3:0]};
                CMD_ENTRY:    id_q     <= bus_q[1];
                CMD_HOME:     cursor_q <= '0;
                CMD_CLEAR: begin
                  cursor_q <= '0;
                  id_q     <= 1'b1;
                  walk_q   <= '0;
                  state_q  <= ST_CLEAR;
`ifdef LCD_RX_BUSY_CHECK_EN
                  cnt_q    <= CNT_W'(CLEAR_BUSY_CYCLES);
`endif
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  // ---- DDRAM: single write port (walk or data write, never both)
  logic [7:0]          mem_q [DDRAM_DEPTH];
  logic                mem_we;
  logic [DDRAM_AW-1:0] mem_wa;
  logic [7:0]          mem_wd;
  logic [7:0]          rd_data_q;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = cursor_q;
    mem_wd = bus_q;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we = 1'b1;
        mem_wa = walk_q;
        mem_wd = LCD_SPACE;
      end else if (xfer_go && rs_q) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Same-edge read of a written index returns the old byte.
  always_ff @(posedge clock) begin
    if (reset) rd_data_q <= 8'h00;
    else       rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data     = rd_data_q;
  assign cursor      = cursor_q;
  assign data_strobe = data_stb_q;
  assign cmd_strobe  = cmd_stb_q;
  assign state_dbg   = state_q;
`ifdef LCD_RX_BUSY_CHECK_EN
  assign busy        = (state_q == ST_CLEAR) || (cnt_q != '0);
  assign violation   = viol_q;
`else
  assign busy        = (state_q == ST_CLEAR);
  assign violation   = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
`timescale 1ns/1ps
module tb_lcd_bus_receiver;
  import lcd_pkg::*;

  localparam int SYNC_STAGES       = 2;
  localparam int CMD_BUSY_CYCLES   = 40;
  localparam int CLEAR_BUSY_CYCLES = 1600;
`ifdef LCD_RX_BUSY_CHECK_EN
  localparam int EXP_CLEAR_RUN = CLEAR_BUSY_CYCLES;
`else
  localparam int EXP_CLEAR_RUN = 32;
`endif

  // ---- clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [4:0] cursor;
  logic       busy, data_strobe, cmd_strobe, violation;
  lcd_state_e state_dbg;

  lcd_bus_receiver_if lcd ();

  lcd_bus_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .CMD_BUSY_CYCLES(CMD_BUSY_CYCLES),
    .CLEAR_BUSY_CYCLES(CLEAR_BUSY_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .lcd(lcd),
    .rd_addr(rd_addr), .rd_data(rd_data), .cursor(cursor), .busy(busy),
    .data_strobe(data_strobe), .cmd_strobe(cmd_strobe),
    .violation(violation), .state_dbg(state_dbg)
  );

  // ---- scoreboard state
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Behavioural model of the display: byte array, cursor, direction.
  logic [7:0] model_mem [32];
  int         model_cur;
  bit         model_id;
  bit         model_viol;
  bit         busy_pending;

  // Strobe and busy-run monitors, sampled on the falling edge.
  int n_ds = 0, n_cs = 0, busy_run = 0, last_busy_run = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (data_strobe) n_ds++;
      if (cmd_strobe)  n_cs++;
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy_run = busy_run;
        busy_run = 0;
      end
    end else begin
      busy_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h20;
    model_cur = 0;
    model_id  = 1'b1;
  endfunction

  function automatic void model_xfer(input bit rs, input bit rw, input logic [7:0] d,
                                     output bit ds, output bit cs);
    ds = 1'b0;
    cs = 1'b0;
    if (!rw) begin
      if (rs) begin
        ds = 1'b1;
        model_mem[model_cur] = d;
        model_cur = model_id ? (model_cur + 1) % 32 : (model_cur + 31) % 32;
      end else begin
        cs = 1'b1;
        if (d >= 8'd128)    model_cur = (d[6] ? 16 : 0) + (d % 16);
        else if (d >= 8'd8) begin end
        else if (d >= 8'd4) model_id = d[1];
        else if (d >= 8'd2) model_cur = 0;
        else if (d == 8'd1) model_reset();
      end
    end
  endfunction

  // ---- driver tasks
  task automatic pulse(input bit rs, input bit rw, input logic [7:0] d, input int settle);
    @(negedge clock);
    lcd.RS = rs; lcd.RW = rw; lcd.bus = d; lcd.enable_l = 1'b0;
    repeat (2) @(negedge clock);
    lcd.enable_l = 1'b1;
    repeat (settle) @(negedge clock);
  endtask

  task automatic do_xfer(input string tag, input bit rs, input bit rw, input logic [7:0] d,
                         input logic [4:0] exp_cur, input int exp_ds, input int exp_cs);
    int ds0, cs0;
    ds0 = n_ds;
    cs0 = n_cs;
    pulse(rs, rw, d, 6);
    check({tag, " cursor"}, cursor, exp_cur);
    check({tag, " data_strobe"}, n_ds - ds0, exp_ds);
    check({tag, " cmd_strobe"}, n_cs - cs0, exp_cs);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s busy_timeout: got busy=1 expected 0 within 4000 cycles", tag);
    end
    repeat (2) @(negedge clock);
    busy_pending = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++) exp_q.push_back(model_mem[i]);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      @(negedge clock);
      check($sformatf("%s mem[%0d]", tag, i), rd_data, exp_q.pop_front());
    end
  endtask

  // ---- directed vectors
  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] d;
    logic [4:0] exp_cur;
    int         exp_ds;
    int         exp_cs;
  } vec_t;
  vec_t tbl[23];

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ds, cs, rs, rw;
    logic [7:0] d;
    int ds0, cs0;

    tbl[0]  = '{1, 0, 8'h41,  1, 1, 0};
    tbl[1]  = '{1, 0, 8'h42,  2, 1, 0};
    tbl[2]  = '{0, 0, 8'hCF, 31, 0, 1};
    tbl[3]  = '{1, 0, 8'h5A,  0, 1, 0};
    tbl[4]  = '{1, 0, 8'h5B,  1, 1, 0};
    tbl[5]  = '{0, 0, 8'h80,  0, 0, 1};
    tbl[6]  = '{0, 0, 8'h04,  0, 0, 1};
    tbl[7]  = '{1, 0, 8'h30, 31, 1, 0};
    tbl[8]  = '{1, 0, 8'h31, 30, 1, 0};
    tbl[9]  = '{0, 0, 8'h02,  0, 0, 1};
    tbl[10] = '{0, 0, 8'h07,  0, 0, 1};
    tbl[11] = '{0, 0, 8'h38,  0, 0, 1};
    tbl[12] = '{0, 0, 8'h0C,  0, 0, 1};
    tbl[13] = '{0, 0, 8'hC5, 21, 0, 1};
    tbl[14] = '{1, 0, 8'h61, 22, 1, 0};
    tbl[15] = '{1, 1, 8'hFF, 22, 0, 0};
    tbl[16] = '{0, 1, 8'hFF, 22, 0, 0};
    tbl[17] = '{0, 0, 8'h03,  0, 0, 1};
    tbl[18] = '{0, 0, 8'h00,  0, 0, 1};
    tbl[19] = '{0, 0, 8'h9F, 15, 0, 1};
    tbl[20] = '{1, 0, 8'h62, 16, 1, 0};
    tbl[21] = '{0, 0, 8'h40, 16, 0, 1};
    tbl[22] = '{0, 0, 8'h10, 16, 0, 1};

    lcd.RS = 1'b0; lcd.RW = 1'b0; lcd.bus = 8'h00; lcd.enable_l = 1'b1;
    rd_addr = 5'd0;
    model_viol = 1'b0;
    busy_pending = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    check("reset busy", busy, 1);
    check("reset rd_data", rd_data, 8'h00);
    check("reset cursor", cursor, 0);
    check("reset data_strobe", data_strobe, 0);
    check("reset cmd_strobe", cmd_strobe, 0);
    check("reset violation", violation, 0);
    check("reset state", state_dbg, ST_CLEAR);
    reset = 1'b0;
    repeat (33) @(negedge clock);
    check("post-walk busy", busy, 0);
    model_reset();
    check_mem("init");

    // Directed table
    for (int i = 0; i < 23; i++) begin
      model_xfer(tbl[i].rs, tbl[i].rw, tbl[i].d, ds, cs);
      do_xfer($sformatf("vec%0d", i), tbl[i].rs, tbl[i].rw, tbl[i].d,
              tbl[i].exp_cur, tbl[i].exp_ds, tbl[i].exp_cs);
    end
    check_mem("table");

    // Clear display, then a data byte that lands inside the walk
    wait_idle("pre-clear");
    model_xfer(0, 0, 8'h04, ds, cs);
    do_xfer("entry dec", 0, 0, 8'h04, 5'(model_cur), 0, 1);
    wait_idle("pre-clear2");
    ds0 = n_ds;
    cs0 = n_cs;
    pulse(0, 0, 8'h01, 0);
    repeat (5) @(negedge clock);
    check("clear busy", busy, 1);
    check("clear cursor", cursor, 0);
    pulse(1, 0, 8'h77, 6);
    wait_idle("clear");
    model_xfer(0, 0, 8'h01, ds, cs);
    check("clear busy run", last_busy_run, EXP_CLEAR_RUN);
    check("clear dropped data_strobe", n_ds - ds0, 0);
    check("clear cmd_strobe", n_cs - cs0, 1);
`ifdef LCD_RX_BUSY_CHECK_EN
    check("clear violation", violation, 1);
`else
    check("clear violation", violation, 0);
`endif
    check_mem("clear");
    model_xfer(1, 0, 8'h55, ds, cs);
    do_xfer("post-clear inc", 1, 0, 8'h55, 5'd1, 1, 0);

    // Reset in the middle of a walk restarts it
    pulse(0, 0, 8'h01, 10);
    check("midwalk busy", busy, 1);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midwalk reset violation", violation, 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("restart busy", busy, 1);
    repeat (14) @(negedge clock);
    check("restart done busy", busy, 0);
    model_reset();
    check("restart cursor", cursor, 0);
    check_mem("restart");
    model_viol = 1'b0;
    busy_pending = 1'b0;

    // Randomized transfers against the model
    for (int i = 0; i < 60; i++) begin
      rw = ($urandom_range(0, 7) == 0);
      rs = $urandom_range(0, 1);
      d  = 8'($urandom_range(0, 255));
      if (!rs && $urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 7));
      if (!rs && $urandom_range(0, 11) == 0) d = 8'h01;
      if (!rw) begin
        if (busy_pending) model_viol = 1'b1;
        busy_pending = 1'b1;
      end
      model_xfer(rs, rw, d, ds, cs);
      do_xfer($sformatf("rnd%0d", i), rs, rw, d, 5'(model_cur), int'(ds), int'(cs));
      if (!rw && !rs && d == 8'h01) wait_idle($sformatf("rnd%0d clear", i));
    end
    check_mem("random");
`ifdef LCD_RX_BUSY_CHECK_EN
    check("random violation", violation, model_viol);
`else
    check("random violation", violation, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
